// File: rtl/jtcps1_pkg.sv
// Shared constants and types for the CPS1 palette copy path.
package jtcps1_pkg;

    localparam int PAL_PAGES     = 6;
    localparam int PAL_PAGE_SIZE = 512;

    localparam logic [2:0] PG_OBJ   = 3'd0;
    localparam logic [2:0] PG_SCR1  = 3'd1;
    localparam logic [2:0] PG_SCR2  = 3'd2;
    localparam logic [2:0] PG_SCR3  = 3'd3;
    localparam logic [2:0] PG_STAR1 = 3'd4;
    localparam logic [2:0] PG_STAR2 = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SCAN,
        ST_READ,
        ST_WRITE,
        ST_FIN
    } dma_state_t;

endpackage

// File: rtl/jtcps1_pal_dma.sv
// Palette copy engine: on the first VB rise after a palette-base write, copies the
// enabled 512-word pages from VRAM into the mixer palette. Star pages need JTCPS1_STARPAL_EN.
module jtcps1_pal_dma
    import jtcps1_pkg::*;
#(
    parameter int PAGES = PAL_PAGES
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        VB,
    input  logic        pal_copy,
    input  logic [7:0]  pal_base,
    input  logic [5:0]  pal_page_en,
    output logic        vram_cs,
    output logic [16:0] vram_addr,
    input  logic [15:0] vram_data,
    input  logic        vram_ok,
    output logic        pal_we,
    output logic [11:0] pal_addr,
    output logic [15:0] pal_data,
    output logic        busy,
    output logic        done
);

`ifdef JTCPS1_STARPAL_EN
    localparam logic [2:0] LAST_PAGE = 3'(PAGES);
`else
    localparam logic [2:0] LAST_PAGE = (PAGES < int'(PG_STAR1)) ? 3'(PAGES) : PG_STAR1;
`endif
    localparam logic [7:0] PAGE_MASK = 8'((1 << int'(LAST_PAGE)) - 1);

    dma_state_t  state_q, state_d;
    logic        pend_q, pend_d;
    logic        vb_q;
    logic [16:0] src_q, src_d;
    logic [2:0]  page_q, page_d;
    logic [8:0]  idx_q, idx_d;
    logic [7:0]  mask_q, mask_d;
    logic [15:0] data_q, data_d;
    logic        start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            vb_q    <= 1'b0;
            src_q   <= '0;
            page_q  <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            vb_q    <= VB;
            src_q   <= src_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        src_d   = src_q;
        page_d  = page_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        data_d  = data_q;
        start   = pend_q && VB && !vb_q && (state_q == ST_IDLE || state_q == ST_ARM);

        // A new request always wins, so a write landing on the start cycle is not lost
        if (pal_copy)   pend_d = 1'b1;
        else if (start) pend_d = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_ARM: begin
                if (start) begin
                    state_d = ST_SCAN;
                    src_d   = {pal_base, 9'd0};
                    page_d  = '0;
                    mask_d  = {2'b00, pal_page_en} & PAGE_MASK;
                end else if (pend_q) begin
                    state_d = ST_ARM;
                end
            end
            ST_SCAN: begin
                if (page_q == LAST_PAGE) begin
                    state_d = ST_FIN;
                end else if (mask_q[page_q]) begin
                    idx_d   = '0;
                    state_d = ST_READ;
                end else begin
                    page_d = page_q + 3'd1;
                end
            end
            ST_READ: begin
                if (vram_ok) begin
                    data_d  = vram_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                src_d = src_q + 17'd1;
                if (idx_q == 9'h1FF) begin
                    page_d  = page_q + 3'd1;
                    state_d = ST_SCAN;
                end else begin
                    idx_d   = idx_q + 9'd1;
                    state_d = ST_READ;
                end
            end
            ST_FIN:  state_d = pend_q ? ST_ARM : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign vram_cs   = (state_q == ST_READ);
    assign vram_addr = src_q;
    assign pal_we    = (state_q == ST_WRITE);
    assign pal_addr  = {page_q, idx_q};
    assign pal_data  = data_q;
    assign busy      = (state_q == ST_SCAN) || (state_q == ST_READ) ||
                       (state_q == ST_WRITE) || (state_q == ST_FIN);
    assign done      = (state_q == ST_FIN);

endmodule

// File: tb/tb_jtcps1_pal_dma.sv
// Scoreboard bench for jtcps1_pal_dma: expected palette writes are queued at request
// time and a negedge monitor pops them against every pal_we.
module tb_jtcps1_pal_dma;

`ifdef JTCPS1_STARPAL_EN
    localparam int NP = 6;
`else
    localparam int NP = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        VB = 1'b0;
    logic        pal_copy = 1'b0;
    logic [7:0]  pal_base = '0;
    logic [5:0]  pal_page_en = '0;
    logic        vram_cs;
    logic [16:0] vram_addr;
    logic [15:0] vram_data = '0;
    logic        vram_ok = 1'b0;
    logic        pal_we;
    logic [11:0] pal_addr;
    logic [15:0] pal_data;
    logic        busy;
    logic        done;

    jtcps1_pal_dma #(.PAGES(6)) dut (
        .clk(clk), .rst_n(rst_n), .VB(VB), .pal_copy(pal_copy),
        .pal_base(pal_base), .pal_page_en(pal_page_en),
        .vram_cs(vram_cs), .vram_addr(vram_addr), .vram_data(vram_data), .vram_ok(vram_ok),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int cyc = 0, edge_cyc = 0, wr_cnt = 0, rd_cyc = 0, done_cnt = 0, done_cyc = 0;
    int ack_dly = 1, rwait = 0;
    logic        first_seen = 1'b0;
    logic [16:0] first_addr = '0;
    logic [11:0] last_addr = '0;
    logic [27:0] expq[$];
    logic [27:0] exp_e;

    function automatic logic [15:0] vdat(input logic [16:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A ^ {15'd0, a[16]};
    endfunction

    function automatic int n_en(input logic [5:0] m);
        int n = 0;
        for (int p = 0; p < NP; p++) if (m[p]) n++;
        return n;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // VRAM model: acknowledges ack_dly cycles after vram_cs rises
    initial forever begin
        @(negedge clk);
        if (vram_cs && !vram_ok) begin
            if (rwait >= ack_dly) begin
                vram_ok   = 1'b1;
                vram_data = vdat(vram_addr);
                rwait     = 0;
            end else begin
                rwait++;
            end
        end else begin
            vram_ok = 1'b0;
            rwait   = 0;
        end
    end

    // Monitor
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (vram_cs) begin
                rd_cyc++;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_addr = vram_addr;
                end
            end
            if (pal_we) begin
                wr_cnt++;
                last_addr = pal_addr;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                             pal_addr, pal_data);
                end else begin
                    exp_e = expq.pop_front();
                    chk("pal_write", {pal_addr, pal_data}, exp_e);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic arm(input logic [7:0] b, input logic [5:0] m);
        logic [16:0] s = {b, 9'd0};
        for (int p = 0; p < NP; p++) begin
            if (m[p]) begin
                for (int i = 0; i < 512; i++) begin
                    expq.push_back({3'(p), 9'(i), vdat(s)});
                    s = s + 17'd1;
                end
            end
        end
        @(negedge clk);
        pal_base    = b;
        pal_page_en = m;
        pal_copy    = 1'b1;
        @(negedge clk);
        pal_copy = 1'b0;
    endtask

    task automatic vb_edge();
        VB = 1'b0;
        @(negedge clk);
        VB = 1'b1;
        edge_cyc   = cyc;
        first_seen = 1'b0;
        wr_cnt     = 0;
        rd_cyc     = 0;
    endtask

    task automatic finish_xfer(input string name, input logic [5:0] m, input int d, input int q_left);
        int words = n_en(m) * 512;
        int exp_n = words * (d + 2) + NP + 2;
        int d0 = done_cnt;
        int t = 0;
        while (done_cnt == d0 && t < exp_n + 100) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done after %0d cycles, required done at %0d", name, t, exp_n);
        end else begin
            chk({name, "_done_cycle"}, done_cyc - edge_cyc, exp_n);
        end
        chk({name, "_writes"}, wr_cnt, words);
        chk({name, "_cs_cycles"}, rd_cyc, words * (d + 1));
        chk({name, "_queue_left"}, expq.size(), q_left);
        @(negedge clk);
        chk({name, "_busy_after"}, busy, 0);
        chk({name, "_done_after"}, done, 0);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_vram_cs"}, vram_cs, 0);
        chk({name, "_vram_addr"}, vram_addr, 0);
        chk({name, "_pal_we"}, pal_we, 0);
        chk({name, "_pal_addr"}, pal_addr, 0);
        chk({name, "_pal_data"}, pal_data, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_wr, snap_rd, snap_done, t;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Full copy, single-cycle ack
        ack_dly = 1;
        arm(8'h12, 6'h3F);
        vb_edge();
        repeat (2) @(negedge clk);
        chk("full_busy_mid", busy, 1);
        finish_xfer("full", 6'h3F, 1, 0);
        chk("full_first_vram_addr", first_addr, 17'h02400);
        chk("full_last_pal_addr", last_addr, {3'(NP - 1), 9'h1FF});

        // Packed SCR1/SCR2
        arm(8'h00, 6'b000110);
        vb_edge();
        finish_xfer("scr12", 6'b000110, 1, 0);
        chk("scr12_first_vram_addr", first_addr, 17'h00000);
        chk("scr12_last_pal_addr", last_addr, 12'h5FF);

        // Empty mask
        arm(8'h44, 6'h00);
        vb_edge();
        finish_xfer("mask0", 6'h00, 1, 0);

        // Star pages only
        arm(8'h05, 6'h30);
        vb_edge();
        finish_xfer("star", 6'h30, 1, 0);

        // Re-request during a transfer, slower ack, second copy wraps the source pointer
        ack_dly = 2;
        arm(8'h20, 6'b000001);
        vb_edge();
        repeat (100) @(negedge clk);
        arm(8'hFF, 6'b000011);
        finish_xfer("first", 6'b000001, 2, n_en(6'b000011) * 512);
        snap_wr   = wr_cnt;
        snap_done = done_cnt;
        repeat (20) @(negedge clk);
        chk("vb_high_no_start_busy", busy, 0);
        chk("vb_high_no_start_writes", wr_cnt, snap_wr);
        chk("vb_high_no_start_done", done_cnt, snap_done);
        vb_edge();
        finish_xfer("second", 6'b000011, 2, 0);

        // Reset while a read is outstanding
        ack_dly = 8;
        arm(8'h30, 6'b000001);
        vb_edge();
        t = 0;
        while (!vram_cs && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rst_read_reached", vram_cs, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("rst_mid");
        expq.delete();
        rst_n = 1'b1;
        snap_wr   = wr_cnt;
        snap_rd   = rd_cyc;
        snap_done = done_cnt;
        VB = 1'b0;
        @(negedge clk);
        VB = 1'b1;
        repeat (5) @(negedge clk);
        VB = 1'b0;
        @(negedge clk);
        VB = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_after_busy", busy, 0);
        chk("rst_after_writes", wr_cnt, snap_wr);
        chk("rst_after_reads", rd_cyc, snap_rd);
        chk("rst_after_done", done_cnt, snap_done);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
